// File: rtl/vector_issue_sequencer.sv
// vector_issue_sequencer
// Takes one decoded vector instruction from Decode and walks it through the
// execute/memory datapath as LANES-wide element beats. ALU instructions issue
// one beat per cycle; loads and stores hold each beat until memory acknowledges.
// Decode is stalled until the instruction retires or is killed.
module vector_issue_sequencer #(
    parameter int VLEN  = 16,
    parameter int LANES = 4,
    parameter int REG_W = 3,
    parameter int IDX_W = $clog2(VLEN),
    parameter int VL_W  = $clog2(VLEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [5:0]       issue_opcode,
    input  logic [REG_W-1:0] issue_vd,
    input  logic [REG_W-1:0] issue_vs1,
    input  logic [REG_W-1:0] issue_vs2,
    input  logic [VL_W-1:0]  issue_vl,
    output logic             issue_ready,
    output logic             stall_decode,
    input  logic             kill,
    output logic             beat_valid,
    output logic [5:0]       beat_opcode,
    output logic [REG_W-1:0] beat_vd,
    output logic [REG_W-1:0] beat_vs1,
    output logic [REG_W-1:0] beat_vs2,
    output logic [IDX_W-1:0] beat_idx,
    output logic [LANES-1:0] lane_mask,
    output logic             beat_last,
    output logic             vreg_we,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             done
);

    localparam logic [5:0] OP_VLOAD  = 6'b110000;
    localparam logic [5:0] OP_VSTORE = 6'b110001;
    // Wide enough for element arithmetic up to VLEN + LANES without wrapping.
    localparam int CW = VL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [5:0]       opcode_r;
    logic [REG_W-1:0] vd_r;
    logic [REG_W-1:0] vs1_r;
    logic [REG_W-1:0] vs2_r;
    logic [VL_W-1:0]  vl_r;
    logic [IDX_W-1:0] beat_cnt_r;

    logic             accept_s;
    logic             issue_is_mem_s;
    logic             is_store_s;
    logic             advance_s;
    logic             last_s;
    logic [VL_W-1:0]  vl_clamp_s;
    logic [CW-1:0]    nbeats_s;
    logic [CW-1:0]    cnt_ext_s;
    logic [CW-1:0]    idx_wide_s;

    // Instruction acceptance and per-instruction derived quantities.
    assign accept_s       = (state_r == ST_IDLE) & issue_valid & issue_opcode[5] & ~kill;
    assign issue_is_mem_s = (issue_opcode == OP_VLOAD) | (issue_opcode == OP_VSTORE);
    assign is_store_s     = (opcode_r == OP_VSTORE);
    assign vl_clamp_s     = (issue_vl > VL_W'(VLEN)) ? VL_W'(VLEN) : issue_vl;
    assign nbeats_s       = ({1'b0, vl_r} + CW'(LANES - 1)) / CW'(LANES);
    assign cnt_ext_s      = CW'(beat_cnt_r);
    assign idx_wide_s     = cnt_ext_s * CW'(LANES);
    assign last_s         = ((cnt_ext_s + CW'(1)) == nbeats_s);
    assign advance_s      = (state_r == ST_ALU) | ((state_r == ST_MEM) & mem_ack);

    // Decode handshake: busy whenever an instruction is in flight.
    assign issue_ready  = (state_r == ST_IDLE);
    assign stall_decode = (state_r != ST_IDLE) | (issue_valid & issue_opcode[5] & ~issue_ready);

    assign beat_opcode = opcode_r;
    assign beat_vd     = vd_r;
    assign beat_vs1    = vs1_r;
    assign beat_vs2    = vs2_r;

    // State register, captured instruction fields and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            opcode_r   <= 6'd0;
            vd_r       <= {REG_W{1'b0}};
            vs1_r      <= {REG_W{1'b0}};
            vs2_r      <= {REG_W{1'b0}};
            vl_r       <= {VL_W{1'b0}};
            beat_cnt_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                opcode_r   <= issue_opcode;
                vd_r       <= issue_vd;
                vs1_r      <= issue_vs1;
                vs2_r      <= issue_vs2;
                vl_r       <= vl_clamp_s;
                beat_cnt_r <= {IDX_W{1'b0}};
            end else if (advance_s && !last_s) begin
                beat_cnt_r <= beat_cnt_r + IDX_W'(1);
            end
        end
    end

    // Next-state: kill returns to IDLE from any busy state without retiring.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (vl_clamp_s == {VL_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else if (issue_is_mem_s) begin
                        state_nxt_s = ST_MEM;
                    end else begin
                        state_nxt_s = ST_ALU;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALU: begin
                if (kill) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ALU;
                end
            end
            ST_MEM: begin
                if (kill) begin
                    state_nxt_s = ST_IDLE;
                end else if (mem_ack && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Beat outputs; element index, mask and last flag read as zero between beats.
    always_comb begin
        beat_valid = 1'b0;
        beat_idx   = {IDX_W{1'b0}};
        lane_mask  = {LANES{1'b0}};
        beat_last  = 1'b0;
        vreg_we    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        case (state_r)
            ST_ALU: begin
                beat_valid = 1'b1;
                vreg_we    = 1'b1;
            end
            ST_MEM: begin
                beat_valid = 1'b1;
                mem_req    = 1'b1;
                mem_we     = is_store_s;
                vreg_we    = ~is_store_s & mem_ack;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
        if (beat_valid) begin
            beat_idx  = idx_wide_s[IDX_W-1:0];
            beat_last = last_s;
            for (int i = 0; i < LANES; i++) begin
                lane_mask[i] = ((idx_wide_s + CW'(i)) < {1'b0, vl_r});
            end
        end else begin
            beat_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Testbench for vector_issue_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the instruction's progress.
module tb_vector_issue_sequencer;

    localparam int VLEN  = 16;
    localparam int LANES = 4;
    localparam int REG_W = 3;
    localparam int IDX_W = 4;
    localparam int VL_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [5:0]       issue_opcode;
    logic [REG_W-1:0] issue_vd, issue_vs1, issue_vs2;
    logic [VL_W-1:0]  issue_vl;
    logic             issue_ready, stall_decode, kill;
    logic             beat_valid;
    logic [5:0]       beat_opcode;
    logic [REG_W-1:0] beat_vd, beat_vs1, beat_vs2;
    logic [IDX_W-1:0] beat_idx;
    logic [LANES-1:0] lane_mask;
    logic             beat_last, vreg_we, mem_req, mem_we, mem_ack, done;

    int n_vec = 0;
    int n_bad = 0;

    // Model: what the accepted instruction is doing.
    // m_phase 0 = no instruction, 1 = issuing beats, 2 = retiring.
    int         m_phase, m_kind, m_vl, m_nb, m_beat;
    logic [5:0] m_op;
    logic [2:0] m_vd, m_vs1, m_vs2;

    int alu_idx_tab[4] = '{0, 4, 8, 12};

    always #5 clk = ~clk;

    vector_issue_sequencer #(.VLEN(VLEN), .LANES(LANES), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_vd(issue_vd), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2),
        .issue_vl(issue_vl), .issue_ready(issue_ready), .stall_decode(stall_decode),
        .kill(kill), .beat_valid(beat_valid), .beat_opcode(beat_opcode),
        .beat_vd(beat_vd), .beat_vs1(beat_vs1), .beat_vs2(beat_vs2),
        .beat_idx(beat_idx), .lane_mask(lane_mask), .beat_last(beat_last),
        .vreg_we(vreg_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model says this cycle must show.
    task automatic compare_all();
        logic       e_bv;
        logic [3:0] e_mask;
        int         e_idx;
        e_bv   = (m_phase == 1);
        e_idx  = e_bv ? m_beat * LANES : 0;
        e_mask = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            if (e_bv && (m_beat * LANES + i < m_vl)) e_mask[i] = 1'b1;
        end
        check("issue_ready", issue_ready, (m_phase == 0));
        check("stall_decode", stall_decode, (m_phase != 0));
        check("beat_valid", beat_valid, e_bv);
        check("beat_idx", beat_idx, e_idx);
        check("lane_mask", lane_mask, e_mask);
        check("beat_last", beat_last, e_bv && (m_beat == m_nb - 1));
        check("vreg_we", vreg_we, e_bv && (m_kind == 0 || (m_kind == 1 && mem_ack)));
        check("mem_req", mem_req, e_bv && (m_kind != 0));
        check("mem_we", mem_we, e_bv && (m_kind == 2));
        check("done", done, (m_phase == 2));
        check("beat_opcode", beat_opcode, m_op);
        check("beat_vd", beat_vd, m_vd);
        check("beat_vs1", beat_vs1, m_vs1);
        check("beat_vs2", beat_vs2, m_vs2);
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_update();
        if (rst) begin
            m_phase = 0; m_kind = 0; m_vl = 0; m_nb = 0; m_beat = 0;
            m_op = 6'd0; m_vd = 3'd0; m_vs1 = 3'd0; m_vs2 = 3'd0;
        end else if (m_phase == 0) begin
            if (issue_valid && issue_opcode[5] && !kill) begin
                m_op   = issue_opcode;
                m_vd   = issue_vd;
                m_vs1  = issue_vs1;
                m_vs2  = issue_vs2;
                m_vl   = (int'(issue_vl) > VLEN) ? VLEN : int'(issue_vl);
                m_nb   = (m_vl + LANES - 1) / LANES;
                m_beat = 0;
                m_kind = (issue_opcode == 6'b110000) ? 1 : (issue_opcode == 6'b110001) ? 2 : 0;
                m_phase = (m_vl == 0) ? 2 : 1;
            end
        end else if (kill) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (m_kind == 0 || mem_ack) begin
                if (m_beat == m_nb - 1) m_phase = 2;
                else m_beat++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [VL_W-1:0] vl);
        issue_valid  = 1'b1;
        issue_opcode = op;
        issue_vl     = vl;
        issue_vd     = 3'd5;
        issue_vs1    = 3'd2;
        issue_vs2    = 3'd7;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; issue_valid = 1'b0; issue_opcode = 6'd0; issue_vd = 3'd0;
        issue_vs1 = 3'd0; issue_vs2 = 3'd0; issue_vl = 5'd0; kill = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        adv();
        adv();
        rst = 1'b0;
        settle();
        check("reset_ready", issue_ready, 1'b1);
        check("reset_beat_valid", beat_valid, 1'b0);
        check("reset_stall", stall_decode, 1'b0);

        // ALU vl=16, a second vector instruction waits behind it.
        set_issue(6'b100010, 5'd16);
        settle();
        adv();
        issue_opcode = 6'b100111;
        for (int b = 0; b < 4; b++) begin
            settle();
            check("alu_idx", beat_idx, alu_idx_tab[b]);
            check("alu_mask", lane_mask, 4'b1111);
            check("alu_last", beat_last, (b == 3));
            check("alu_we", vreg_we, 1'b1);
            check("alu_stall", stall_decode, 1'b1);
            check("alu_vd", beat_vd, 3'd5);
            adv();
        end
        settle();
        check("alu_done", done, 1'b1);
        check("alu_done_stall", stall_decode, 1'b1);
        adv();
        kill = 1'b1;
        settle();
        check("idle_stall", stall_decode, 1'b0);
        adv();
        issue_valid = 1'b0; kill = 1'b0;
        settle();
        check("kill_idle_ready", issue_ready, 1'b1);
        adv();

        // VLOAD vl=6 with two wait cycles per beat.
        set_issue(6'b110000, 5'd6);
        mem_ack = 1'b0;
        settle();
        adv();
        issue_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 3; w++) begin
                mem_ack = (w == 2);
                settle();
                check("ld_req", mem_req, 1'b1);
                check("ld_we", mem_we, 1'b0);
                check("ld_idx", beat_idx, b * 4);
                check("ld_mask", lane_mask, (b == 0) ? 4'b1111 : 4'b0011);
                check("ld_vreg_we", vreg_we, (w == 2));
                adv();
            end
        end
        mem_ack = 1'b0;
        settle();
        check("ld_done", done, 1'b1);
        adv();

        // VSTORE vl=16 with mem_ack tied high.
        set_issue(6'b110001, 5'd16);
        mem_ack = 1'b1;
        settle();
        adv();
        issue_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            settle();
            check("st_we", mem_we, 1'b1);
            check("st_vreg_we", vreg_we, 1'b0);
            check("st_idx", beat_idx, alu_idx_tab[b]);
            adv();
        end
        mem_ack = 1'b0;
        settle();
        check("st_done", done, 1'b1);
        adv();

        // vl=0 retires next cycle with no beats.
        set_issue(6'b100001, 5'd0);
        settle();
        adv();
        issue_valid = 1'b0;
        settle();
        check("vl0_done", done, 1'b1);
        check("vl0_bv", beat_valid, 1'b0);
        adv();

        // vl=20 clamps to 16 elements.
        set_issue(6'b100001, 5'd20);
        settle();
        adv();
        issue_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (beat_valid) cnt++;
            adv();
        end
        check("vl20_beats", cnt, 4);

        // Scalar opcode is ignored.
        set_issue(6'b000011, 5'd8);
        settle();
        check("scalar_stall", stall_decode, 1'b0);
        adv();
        settle();
        check("scalar_ready", issue_ready, 1'b1);
        issue_valid = 1'b0;
        adv();

        // Kill during ALU beat 2: the kill-cycle write still happens, no done.
        set_issue(6'b100100, 5'd16);
        settle();
        adv();
        issue_valid = 1'b0;
        settle(); adv();
        settle(); adv();
        kill = 1'b1;
        settle();
        check("kill_alu_we", vreg_we, 1'b1);
        adv();
        kill = 1'b0;
        settle();
        check("kill_alu_bv", beat_valid, 1'b0);
        check("kill_alu_done", done, 1'b0);
        adv();

        // Kill while a load waits for memory.
        set_issue(6'b110000, 5'd8);
        settle();
        adv();
        issue_valid = 1'b0;
        settle(); adv();
        kill = 1'b1;
        settle();
        check("kill_mem_req", mem_req, 1'b1);
        adv();
        kill = 1'b0;
        settle();
        check("kill_mem_drop", mem_req, 1'b0);
        adv();

        // Reset in the middle of an ALU instruction.
        set_issue(6'b101010, 5'd12);
        settle();
        adv();
        issue_valid = 1'b0;
        settle(); adv();
        rst = 1'b1;
        settle();
        adv();
        rst = 1'b0;
        settle();
        check("rst_bv", beat_valid, 1'b0);
        check("rst_op", beat_opcode, 6'd0);
        check("rst_ready", issue_ready, 1'b1);
        adv();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            int sel;
            sel = $urandom_range(0, 3);
            issue_valid = ($urandom_range(0, 1) == 1);
            case (sel)
                0: issue_opcode = {1'b0, 5'($urandom_range(0, 31))};
                1: issue_opcode = 6'b110000;
                2: issue_opcode = 6'b110001;
                default: issue_opcode = {1'b1, 5'($urandom_range(0, 31))};
            endcase
            issue_vl  = 5'($urandom_range(0, 20));
            issue_vd  = 3'($urandom_range(0, 7));
            issue_vs1 = 3'($urandom_range(0, 7));
            issue_vs2 = 3'($urandom_range(0, 7));
            mem_ack   = ($urandom_range(0, 1) == 1);
            kill      = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            settle();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
